// File: rtl/color_pkg.sv
// color_pkg: shared pixel, channel-select and configuration types for the colour unscrambler.
package color_pkg;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        CH_R    = 2'b00,
        CH_G    = 2'b01,
        CH_B    = 2'b10,
        CH_ZERO = 2'b11
    } chsel_e;

    localparam logic [5:0] CFG_IDENTITY = 6'b00_01_10;
endpackage

// File: rtl/color_inverse_map.sv
// color_inverse_map: combinational inverse of the channel scrambler.
// cfg fields are {R,G,B} source selects; each original channel comes from the first output that carried it.
module color_inverse_map
    import color_pkg::*;
(
    input  logic [5:0] i_cfg,
    input  rgb444_t    i_rgb,
    output rgb444_t    o_color,
    output logic [2:0] o_lost
);
    function automatic logic [4:0] pick(chsel_e j, logic [5:0] cfg, rgb444_t rgb);
        return (cfg[5:4] == j) ? {1'b0, rgb.r} :
               (cfg[3:2] == j) ? {1'b0, rgb.g} :
               (cfg[1:0] == j) ? {1'b0, rgb.b} : 5'b1_0000;
    endfunction

    assign {o_lost[2], o_color.r} = pick(CH_R, i_cfg, i_rgb);
    assign {o_lost[1], o_color.g} = pick(CH_G, i_cfg, i_rgb);
    assign {o_lost[0], o_color.b} = pick(CH_B, i_cfg, i_rgb);
endmodule

// File: rtl/color_unscrambler.sv
// color_unscrambler: two-stage valid/ready pipeline restoring scrambled RGB444 channels.
// Switch code is synchronised and only adopted on an accepted start-of-frame beat.
module color_unscrambler
    import color_pkg::*;
#(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:10]     SW,
    input  logic [11:0]      in_rgb,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [11:0]      out_color,
    output logic             out_valid,
    output logic             out_sof,
    input  logic             out_ready,
    output logic [2:0]       out_lost,
    output logic [5:0]       cfg_active,
    output logic [CNT_W-1:0] frame_pixels,
    output logic             frame_done
);
    logic [5:0]       r_sw_meta, r_sw_sync, r_s1_cfg;
    logic             r_s1_valid, r_s1_sof;
    rgb444_t          r_s1_rgb;
    logic [CNT_W-1:0] r_count;
    logic             w_s2_adv, w_accept, w_sof_acc;
    logic [5:0]       w_cfg;
    rgb444_t          w_map_color;
    logic [2:0]       w_map_lost;

    assign w_s2_adv  = !out_valid | out_ready;
    assign in_ready  = !r_s1_valid | w_s2_adv;
    assign w_accept  = in_valid & in_ready;
    assign w_sof_acc = w_accept & in_sof;
    // The sof beat itself must already use the newly adopted code.
    assign w_cfg     = w_sof_acc ? r_sw_sync : cfg_active;

    color_inverse_map u_map (
        .i_cfg  (r_s1_cfg),
        .i_rgb  (r_s1_rgb),
        .o_color(w_map_color),
        .o_lost (w_map_lost)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            cfg_active <= CFG_IDENTITY;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            if (w_sof_acc) cfg_active <= r_sw_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_rgb   <= '0;
            r_s1_cfg   <= CFG_IDENTITY;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sof <= in_sof;
                r_s1_rgb <= in_rgb;
                r_s1_cfg <= w_cfg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_color <= '0;
            out_lost  <= '0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_sof   <= r_s1_sof;
                out_color <= w_map_color;
                out_lost  <= w_map_lost;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            frame_pixels <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_accept) begin
                if (in_sof) begin
                    r_count <= CNT_W'(1);
                    if (r_count != '0) begin
                        frame_pixels <= r_count;
                        frame_done   <= 1'b1;
                    end
                end else if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_color_unscrambler.sv
// tb_color_unscrambler: directed vectors plus a scoreboard and stall-hold monitor.
module tb_color_unscrambler;
    localparam int CNT_W = 19;
    localparam logic [5:0] ID = 6'b00_01_10;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:10]     SW;
    logic [11:0]      in_rgb;
    logic             in_valid, in_sof, in_ready;
    logic [11:0]      out_color;
    logic             out_valid, out_sof, out_ready;
    logic [2:0]       out_lost;
    logic [5:0]       cfg_active;
    logic [CNT_W-1:0] frame_pixels;
    logic             frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    always #5 clk = ~clk;

    color_unscrambler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .SW(SW), .in_rgb(in_rgb), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .out_color(out_color), .out_valid(out_valid),
        .out_sof(out_sof), .out_ready(out_ready), .out_lost(out_lost), .cfg_active(cfg_active),
        .frame_pixels(frame_pixels), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent model: later (lower-priority) matches are overwritten by earlier ones.
    function automatic logic [14:0] model(logic [5:0] cfg, logic [11:0] px);
        logic [11:0] c;
        logic [2:0]  l;
        c = '0;
        l = 3'b111;
        for (int j = 0; j < 3; j++)
            for (int k = 2; k >= 0; k--)
                if (cfg[5-2*k -: 2] == 2'(j)) begin
                    c[11-4*j -: 4] = px[11-4*k -: 4];
                    l[2-j] = 1'b0;
                end
        return {l, c};
    endfunction

    logic [15:0] q[$];
    logic [5:0]  m_cfg;
    logic [15:0] e;
    logic        stall = 1'b0;
    logic [11:0] h_color;
    logic [2:0]  h_lost;
    logic        h_sof;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_cfg = ID;
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_color", 32'(out_color), 32'(h_color));
                check("hold_lost", 32'(out_lost), 32'(h_lost));
                check("hold_sof", 32'(out_sof), 32'(h_sof));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) check("sb_extra", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("sb_color", 32'(out_color), 32'(e[11:0]));
                    check("sb_lost", 32'(out_lost), 32'(e[14:12]));
                    check("sb_sof", 32'(out_sof), 32'(e[15]));
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) m_cfg = SW;
                q.push_back({in_sof, model(m_cfg, in_rgb)});
            end
            stall   = out_valid && !out_ready;
            h_color = out_color;
            h_lost  = out_lost;
            h_sof   = out_sof;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [11:0] px, input logic sof);
        in_valid = 1'b1;
        in_rgb   = px;
        in_sof   = sof;
        @(posedge clk); #1;
    endtask

    task automatic set_sw(input logic [5:0] v);
        SW = v;
        repeat (3) idle();
    endtask

    initial begin
        int sent, cyc, n0;
        logic acc;
        SW = ID; in_valid = 0; in_rgb = '0; in_sof = 0; out_ready = 1; reset = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof", 32'(out_sof), 32'd0);
        check("rst_out_color", 32'(out_color), 32'd0);
        check("rst_out_lost", 32'(out_lost), 32'd0);
        check("rst_cfg", 32'(cfg_active), 32'(ID));
        check("rst_fpix", 32'(frame_pixels), 32'd0);
        check("rst_fdone", 32'(frame_done), 32'd0);
        reset = 0;
        set_sw(ID);
        beat(12'hABC, 1'b1);
        beat(12'h123, 1'b0);
        check("id_v0", 32'(out_valid), 32'd1);
        check("id_c0", 32'(out_color), 32'hABC);
        check("id_sof0", 32'(out_sof), 32'd1);
        check("id_l0", 32'(out_lost), 32'd0);
        idle();
        check("id_c1", 32'(out_color), 32'h123);
        check("id_sof1", 32'(out_sof), 32'd0);
        idle();
        check("id_drain", 32'(out_valid), 32'd0);

        set_sw(6'b01_00_10);
        beat(12'h5A3, 1'b1);
        idle();
        check("swap1", 32'(out_color), 32'hA53);
        check("swap1_cfg", 32'(cfg_active), 32'h12);
        set_sw(6'b10_01_00);
        beat(12'h5A3, 1'b1);
        idle();
        check("swap2", 32'(out_color), 32'h3A5);
        set_sw(6'b00_00_11);
        beat(12'h7E1, 1'b1);
        idle();
        check("loss_c", 32'(out_color), 32'h700);
        check("loss_l", 32'(out_lost), 32'h3);
        set_sw(6'b11_11_11);
        beat(12'hFFF, 1'b1);
        idle();
        check("all_lost_c", 32'(out_color), 32'h000);
        check("all_lost_l", 32'(out_lost), 32'h7);

        set_sw(ID);
        beat(12'h5A3, 1'b1);
        idle();
        check("mid_pre", 32'(out_color), 32'h5A3);
        set_sw(6'b01_00_10);
        beat(12'h5A3, 1'b0);
        idle();
        check("mid_hold_c", 32'(out_color), 32'h5A3);
        check("mid_hold_cfg", 32'(cfg_active), 32'(ID));
        beat(12'h5A3, 1'b1);
        idle();
        check("mid_new_c", 32'(out_color), 32'hA53);
        check("mid_new_cfg", 32'(cfg_active), 32'h12);

        reset = 1; @(posedge clk); #1; reset = 0;
        set_sw(ID);
        beat(12'h001, 1'b1);
        check("fc_first_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 4; i++) beat(12'h010, 1'b0);
        beat(12'h002, 1'b1);
        check("fc5_done", 32'(frame_done), 32'd1);
        check("fc5_pix", 32'(frame_pixels), 32'd5);
        beat(12'h020, 1'b0);
        check("fc_pulse", 32'(frame_done), 32'd0);
        beat(12'h020, 1'b0);
        beat(12'h003, 1'b1);
        check("fc3_done", 32'(frame_done), 32'd1);
        check("fc3_pix", 32'(frame_pixels), 32'd3);
        idle();

        set_sw(6'b01_00_10);
        beat(12'h111, 1'b1);
        out_ready = 0;
        beat(12'h222, 1'b0);
        beat(12'h333, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #1 reset = 1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_color", 32'(out_color), 32'd0);
        check("mr_lost", 32'(out_lost), 32'd0);
        check("mr_sof", 32'(out_sof), 32'd0);
        check("mr_cfg", 32'(cfg_active), 32'(ID));
        check("mr_fpix", 32'(frame_pixels), 32'd0);
        check("mr_fdone", 32'(frame_done), 32'd0);
        in_valid = 0; in_sof = 0; out_ready = 1;
        @(posedge clk); #1 reset = 0;
        repeat (3) idle();
        beat(12'h5A3, 1'b0);
        idle();
        check("post_rst_id", 32'(out_color), 32'h5A3);

        set_sw(6'b10_00_01);
        n0 = n_out; sent = 0; cyc = 0;
        in_valid = 1; in_rgb = 12'($urandom); in_sof = ($urandom_range(0, 15) == 0);
        while (sent < 1000 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_rgb = 12'($urandom);
                in_sof = ($urandom_range(0, 15) == 0);
            end
        end
        in_valid = 0; in_sof = 0; out_ready = 1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) idle();
        check("bp_sent", 32'(sent), 32'd1000);
        check("bp_out", 32'(n_out - n0), 32'd1000);
        check("bp_drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
